// File: rtl/mips_mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states
// and the alignment rule applied at request acceptance.
package mips_mem_pkg;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP, ERR} state_e;

  // The unused size encoding is rejected the same way as a misaligned access.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return off[0];
      SZ_WORD: return |off;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/mem_lane_align.sv
// Big-endian lane steering: extract+extend a load lane from a memory word, and
// merge a right-justified store lane into a memory word for read-modify-write.
module mem_lane_align
  import mips_mem_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic        isUnsigned,
  input  logic [31:0] word,
  input  logic [31:0] data,
  output logic [31:0] loadData,
  output logic [31:0] mergedWord
);
  localparam int NUM_LANES = 4;

  // Lane 3 is byte offset 0 (bits 31:24), lane 0 is byte offset 3.
  logic [NUM_LANES-1:0][7:0] wordB, dataB, mergeB;
  assign wordB = word;
  assign dataB = data;
  assign mergedWord = mergeB;

  always_comb begin
    logic [7:0]  b;
    logic [15:0] h;
    b = wordB[2'd3 - offset];
    h = offset[1] ? word[15:0] : word[31:16];
    case (size)
      SZ_BYTE: loadData = {{24{~isUnsigned & b[7]}}, b};
      SZ_HALF: loadData = {{16{~isUnsigned & h[15]}}, h};
      default: loadData = word;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : gLane
    localparam logic [1:0] OFF = 2'(NUM_LANES - 1 - i);
    logic       sel;
    logic [7:0] src;
    always_comb begin
      sel = 1'b1;
      src = dataB[i];
      case (size)
        SZ_BYTE: begin
          sel = (OFF == offset);
          src = dataB[0];
        end
        SZ_HALF: begin
          sel = (OFF[1] == offset[1]);
          src = OFF[0] ? dataB[0] : dataB[1];
        end
        default: ;
      endcase
    end
    assign mergeB[i] = sel ? src : wordB[i];
  end
endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator: one request at a time, sub-word stores done as
// read-modify-write on a word-only memory; all outputs decode registered state.
module mem_access_unit
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misalign,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata
);
  state_e state, stateNext;

  logic [1:0]        offQ, sizeQ;
  logic              unsQ, wrQ;
  logic [DATA_W-1:0] wdataQ;
  logic [31:0]       loadData, mergedWord;
  logic              accept, misalign;

  assign accept   = req_valid & req_ready;
  assign misalign = isMisaligned(req_size, req_addr[1:0]);

  mem_lane_align uAlign (
    .offset     (offQ),
    .size       (sizeQ),
    .isUnsigned (unsQ),
    .word       (mem_rdata),
    .data       (wdataQ),
    .loadData   (loadData),
    .mergedWord (mergedWord)
  );

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:
        if (req_valid) begin
          if (misalign)                            stateNext = ERR;
          else if (req_write && req_size == SZ_WORD) stateNext = WR;
          else                                     stateNext = RD;
        end
      RD:      stateNext = CAP;
      CAP:     stateNext = wrQ ? WR : RESP;
      WR:      stateNext = RESP;
      RESP:    stateNext = IDLE;
      ERR:     stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    req_ready     = (state == IDLE);
    mem_read      = (state == RD);
    mem_write     = (state == WR);
    resp_valid    = (state == RESP) || (state == ERR);
    resp_misalign = (state == ERR);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      offQ       <= '0;
      sizeQ      <= SZ_BYTE;
      unsQ       <= 1'b0;
      wrQ        <= 1'b0;
      wdataQ     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      resp_rdata <= '0;
    end else begin
      state <= stateNext;
      if (accept) begin
        offQ     <= req_addr[1:0];
        sizeQ    <= req_size;
        unsQ     <= req_unsigned;
        wrQ      <= req_write;
        wdataQ   <= req_wdata;
        mem_addr <= {req_addr[ADDR_W-1:2], 2'b00};
        if (req_write && req_size == SZ_WORD && !misalign) mem_wdata <= req_wdata;
      end
      // mem_rdata is only valid in CAP; it feeds either the load result or the RMW word.
      if (state == CAP) begin
        if (wrQ) mem_wdata  <= mergedWord;
        else     resp_rdata <= loadData;
      end
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: directed requests push expected responses,
// a negedge monitor pops and compares them, and a word memory model answers strobes.
module tb_mem_access_unit;
  import mips_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_misalign;
  logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_read, mem_write;

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_misalign(resp_misalign), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata)
  );

  typedef struct {
    logic        mis;
    logic        chkData;
    logic [31:0] rdata;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   nVec = 0, nErr = 0, cyc = 0;
  bit   chkReady = 1'b0;

  logic [31:0] mem [0:63];
  logic        preEn = 1'b0;
  logic [31:0] preAddr = '0, preData = '0;
  int          memReads = 0, memWrites = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (preEn) mem[preAddr[7:2]] <= preData;
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[7:2]];
      memReads  <= memReads + 1;
    end
    if (mem_write) begin
      mem[mem_addr[7:2]] <= mem_wdata;
      memWrites <= memWrites + 1;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    nVec++;
    nErr++;
    $display("FAIL %s", name);
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    preEn = 1'b1; preAddr = addr; preData = data;
    @(posedge clk); #1;
    preEn = 1'b0;
  endtask

  task automatic doReq(input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic mis, input logic chkD, input logic [31:0] rd,
                       input int lat, input bit push, input bit hold, output int acc);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    req_write = wr; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      fail("accept timeout");
      req_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk); #1;
      acc = cyc - 1;
      e.mis = mis; e.chkData = chkD; e.rdata = rd; e.lat = lat; e.acc = acc;
      if (push) q.push_back(e);
      if (!hold) req_valid = 1'b0;
    end
  endtask

  task automatic waitDone();
    int n = 0;
    while (q.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail("response timeout");
      q.delete();
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (chkReady) check("req_ready", {31'b0, req_ready}, {31'b0, q.size() == 0});
      if (mem_read || mem_write) check("strobe overlap", {31'b0, mem_read & mem_write}, 32'd0);
      if (resp_valid) begin
        if (q.size() == 0) fail("unexpected resp_valid");
        else begin
          exp_t e;
          e = q.pop_front();
          check("resp_misalign", {31'b0, resp_misalign}, {31'b0, e.mis});
          check("latency", cyc - e.acc, e.lat);
          if (e.chkData) check("resp_rdata", resp_rdata, e.rdata);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int acc, acc2, r0, w0;
    rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_size = SZ_BYTE;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset req_ready", {31'b0, req_ready}, 32'd1);
    check("reset resp_valid", {31'b0, resp_valid}, 32'd0);
    check("reset resp_misalign", {31'b0, resp_misalign}, 32'd0);
    check("reset mem_read", {31'b0, mem_read}, 32'd0);
    check("reset mem_write", {31'b0, mem_write}, 32'd0);
    check("reset mem_addr", mem_addr, 32'd0);
    check("reset mem_wdata", mem_wdata, 32'd0);
    check("reset resp_rdata", resp_rdata, 32'd0);
    rst = 1'b0;
    chkReady = 1'b1;

    // Word store then word load
    doReq(1, SZ_WORD, 0, 32'h20, 32'hDEADBEEF, 0, 0, 0, 2, 1, 0, acc);
    @(negedge clk);
    check("SW mem_write", {31'b0, mem_write}, 32'd1);
    check("SW mem_wdata", mem_wdata, 32'hDEADBEEF);
    check("SW mem_addr", mem_addr, 32'h20);
    waitDone();
    doReq(0, SZ_WORD, 0, 32'h20, 0, 0, 1, 32'hDEADBEEF, 3, 1, 0, acc);
    waitDone();

    // Sub-word store read-modify-write
    preload(32'h40, 32'h11223344);
    doReq(1, SZ_BYTE, 0, 32'h42, 32'h123456AA, 0, 0, 0, 4, 1, 0, acc);
    @(negedge clk);
    check("SB mem_read", {31'b0, mem_read}, 32'd1);
    check("SB mem_addr", mem_addr, 32'h40);
    @(negedge clk);
    @(negedge clk);
    check("SB mem_write", {31'b0, mem_write}, 32'd1);
    check("SB mem_wdata", mem_wdata, 32'h1122AA44);
    waitDone();
    doReq(0, SZ_WORD, 0, 32'h40, 0, 0, 1, 32'h1122AA44, 3, 1, 0, acc);
    waitDone();

    // Sign/zero extension of byte and half lanes
    preload(32'h40, 32'h80FF7F01);
    doReq(0, SZ_BYTE, 0, 32'h41, 0, 0, 1, 32'hFFFFFFFF, 3, 1, 0, acc); waitDone();
    doReq(0, SZ_BYTE, 1, 32'h41, 0, 0, 1, 32'h000000FF, 3, 1, 0, acc); waitDone();
    doReq(0, SZ_HALF, 0, 32'h40, 0, 0, 1, 32'hFFFF80FF, 3, 1, 0, acc); waitDone();
    doReq(0, SZ_HALF, 1, 32'h42, 0, 0, 1, 32'h00007F01, 3, 1, 0, acc); waitDone();
    doReq(1, SZ_HALF, 0, 32'h42, 32'h0000BEEF, 0, 0, 0, 4, 1, 0, acc); waitDone();
    doReq(0, SZ_WORD, 0, 32'h40, 0, 0, 1, 32'h80FFBEEF, 3, 1, 0, acc); waitDone();
    doReq(0, SZ_BYTE, 0, 32'h43, 0, 0, 1, 32'hFFFFFFEF, 3, 1, 0, acc); waitDone();

    // Misaligned and illegal-size requests never touch memory
    r0 = memReads; w0 = memWrites;
    doReq(0, SZ_WORD, 0, 32'h22, 0, 1, 0, 0, 1, 1, 0, acc); waitDone();
    doReq(1, SZ_HALF, 0, 32'h21, 32'h5555, 1, 0, 0, 1, 1, 0, acc); waitDone();
    doReq(1, 2'b11, 0, 32'h20, 32'h01234567, 1, 0, 0, 1, 1, 0, acc); waitDone();
    @(negedge clk);
    check("misalign mem reads", memReads, r0);
    check("misalign mem writes", memWrites, w0);
    check("misalign memory word", mem[8], 32'hDEADBEEF);

    // Reset during CAP of a sub-word store
    preload(32'h40, 32'h11223344);
    chkReady = 1'b0;
    w0 = memWrites;
    doReq(1, SZ_BYTE, 0, 32'h42, 32'hAA, 0, 0, 0, 0, 0, 0, acc);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort req_ready", {31'b0, req_ready}, 32'd1);
    check("abort mem_write", {31'b0, mem_write}, 32'd0);
    check("abort resp_valid", {31'b0, resp_valid}, 32'd0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("abort mem writes", memWrites, w0);
    check("abort memory word", mem[16], 32'h11223344);
    chkReady = 1'b1;

    // Back-to-back loads with req_valid held
    doReq(0, SZ_WORD, 0, 32'h40, 0, 0, 1, 32'h11223344, 3, 1, 1, acc);
    doReq(0, SZ_WORD, 0, 32'h20, 0, 0, 1, 32'hDEADBEEF, 3, 1, 0, acc2);
    check("back-to-back spacing", acc2 - acc, 32'd4);
    waitDone();

    repeat (3) @(negedge clk);
    check("leftover responses", q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end
endmodule
